// File: rtl/memwb_pipe_reg_pkg.sv
// Shared definitions for the MEM/WB pipeline register.
//   DATA_W_DEF / ADDR_W_DEF : default field widths
//   REG_ZERO                : architectural zero register, never written or forwarded
//   MIN_DEPTH / MAX_DEPTH   : legal range of register stages
//   BUBBLE_*                : field values loaded into a stage to form a bubble
package memwb_pipe_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int MIN_DEPTH  = 1;
    localparam int MAX_DEPTH  = 4;

    // A bubble is an all-zero stage: not valid, no write, ALU source,
    // zero data and zero destination.
    localparam logic BUBBLE_VALID = 1'b0;
    localparam logic BUBBLE_WB    = 1'b0;
    localparam logic BUBBLE_WBSRC = 1'b0;
    localparam logic BUBBLE_FILL  = 1'b0;

endpackage

// File: rtl/memwb_pipe_reg_if.sv
// MEM/WB stage bus: MEM-side inputs, hazard controls and WB-side outputs.
//   master : drives stall/flush and the MEM-stage fields, observes WB outputs
//   slave  : the pipeline register itself
interface memwb_pipe_reg_if
    import memwb_pipe_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic              WB_i;
    logic              WBSrc_i;
    logic [DATA_W-1:0] MemRdata_i;
    logic [DATA_W-1:0] ALUres_i;
    logic [ADDR_W-1:0] rd_addr_i;

    logic              valid_o;
    logic              WB_o;
    logic              WBSrc_o;
    logic [DATA_W-1:0] MemRdata_o;
    logic [DATA_W-1:0] ALUres_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              fwd_en_o;

    modport master (
        output stall_i, flush_i, valid_i, WB_i, WBSrc_i, MemRdata_i, ALUres_i, rd_addr_i,
        input  valid_o, WB_o, WBSrc_o, MemRdata_o, ALUres_o, rd_addr_o, wb_data_o, fwd_en_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, WB_i, WBSrc_i, MemRdata_i, ALUres_i, rd_addr_i,
        output valid_o, WB_o, WBSrc_o, MemRdata_o, ALUres_o, rd_addr_o, wb_data_o, fwd_en_o
    );
endinterface

// File: rtl/memwb_stage.sv
// One clocked MEM/WB stage.
//   clk, rst_n : clock and asynchronous active-low clear
//   hold       : keep current contents
//   bubble     : load the bubble encoding (takes priority over hold)
//   d_* / q_*  : valid, WB, WBSrc, MemRdata, ALUres, rd_addr in / out
module memwb_stage
    import memwb_pipe_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              bubble,
    input  logic              d_valid,
    input  logic              d_wb,
    input  logic              d_wbsrc,
    input  logic [DATA_W-1:0] d_mem,
    input  logic [DATA_W-1:0] d_alu,
    input  logic [ADDR_W-1:0] d_rd,
    output logic              q_valid,
    output logic              q_wb,
    output logic              q_wbsrc,
    output logic [DATA_W-1:0] q_mem,
    output logic [DATA_W-1:0] q_alu,
    output logic [ADDR_W-1:0] q_rd
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_wb    <= 1'b0;
            q_wbsrc <= 1'b0;
            q_mem   <= '0;
            q_alu   <= '0;
            q_rd    <= '0;
        end else if (bubble) begin
            q_valid <= BUBBLE_VALID;
            q_wb    <= BUBBLE_WB;
            q_wbsrc <= BUBBLE_WBSRC;
            q_mem   <= {DATA_W{BUBBLE_FILL}};
            q_alu   <= {DATA_W{BUBBLE_FILL}};
            q_rd    <= {ADDR_W{BUBBLE_FILL}};
        end else if (!hold) begin
            q_valid <= d_valid;
            q_wb    <= d_wb;
            q_wbsrc <= d_wbsrc;
            q_mem   <= d_mem;
            q_alu   <= d_alu;
            q_rd    <= d_rd;
        end
    end

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with DEPTH stages, stall, flush and valid tracking.
//   clk_i : core clock, rising edge
//   rst_i : asynchronous active-low reset; first edge after release captures nothing
//   bus   : slave side of memwb_pipe_reg_if (MEM inputs, stall/flush, WB outputs,
//           selected write-back data and forwarding enable)
module memwb_pipe_reg
    import memwb_pipe_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    memwb_pipe_reg_if.slave  bus
);

    if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_depth_check
        $error("memwb_pipe_reg: DEPTH must lie in 1..4");
    end

    // Cleared by reset, set on the first edge afterwards. Gating all stages
    // with it keeps the release edge from capturing anything.
    logic run_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    logic              st_valid [DEPTH];
    logic              st_wb    [DEPTH];
    logic              st_wbsrc [DEPTH];
    logic [DATA_W-1:0] st_mem   [DEPTH];
    logic [DATA_W-1:0] st_alu   [DEPTH];
    logic [ADDR_W-1:0] st_rd    [DEPTH];

    // Write enable is qualified once, at capture, so later stages never
    // need to look at the destination again.
    logic wb_qual;
    assign wb_qual = bus.WB_i & bus.valid_i & (bus.rd_addr_i != ADDR_W'(REG_ZERO));

    logic stage_hold;
    assign stage_hold = bus.stall_i | ~run_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            // Flush overrides stall for the head stage only.
            memwb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
                .clk     (clk_i),
                .rst_n   (rst_i),
                .hold    (stage_hold),
                .bubble  (bus.flush_i & run_reg),
                .d_valid (bus.valid_i),
                .d_wb    (wb_qual),
                .d_wbsrc (bus.WBSrc_i),
                .d_mem   (bus.MemRdata_i),
                .d_alu   (bus.ALUres_i),
                .d_rd    (bus.rd_addr_i),
                .q_valid (st_valid[gi]),
                .q_wb    (st_wb[gi]),
                .q_wbsrc (st_wbsrc[gi]),
                .q_mem   (st_mem[gi]),
                .q_alu   (st_alu[gi]),
                .q_rd    (st_rd[gi])
            );
        end else begin : g_tail
            memwb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
                .clk     (clk_i),
                .rst_n   (rst_i),
                .hold    (stage_hold),
                .bubble  (1'b0),
                .d_valid (st_valid[gi-1]),
                .d_wb    (st_wb[gi-1]),
                .d_wbsrc (st_wbsrc[gi-1]),
                .d_mem   (st_mem[gi-1]),
                .d_alu   (st_alu[gi-1]),
                .d_rd    (st_rd[gi-1]),
                .q_valid (st_valid[gi]),
                .q_wb    (st_wb[gi]),
                .q_wbsrc (st_wbsrc[gi]),
                .q_mem   (st_mem[gi]),
                .q_alu   (st_alu[gi]),
                .q_rd    (st_rd[gi])
            );
        end
    end

    assign bus.valid_o    = st_valid[DEPTH-1];
    assign bus.WB_o       = st_wb[DEPTH-1];
    assign bus.WBSrc_o    = st_wbsrc[DEPTH-1];
    assign bus.MemRdata_o = st_mem[DEPTH-1];
    assign bus.ALUres_o   = st_alu[DEPTH-1];
    assign bus.rd_addr_o  = st_rd[DEPTH-1];
    assign bus.wb_data_o  = st_wbsrc[DEPTH-1] ? st_mem[DEPTH-1] : st_alu[DEPTH-1];
    assign bus.fwd_en_o   = st_wb[DEPTH-1];

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Drives three copies of memwb_pipe_reg (DEPTH 1, 2, 3) with the same stimulus
// and compares each against a reference model through a scoreboard.
module tb_memwb_pipe_reg;
    import memwb_pipe_reg_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ND = 3;

    typedef struct packed {
        logic          valid;
        logic          wb;
        logic          wbsrc;
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic [AW-1:0] rd;
        logic [DW-1:0] wbdata;
        logic          fwd;
    } out_t;

    typedef struct packed {
        logic          valid;
        logic          wb;
        logic          wbsrc;
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic [AW-1:0] rd;
    } st_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          stall = 0, flush = 0, valid = 0, wb = 0, wbsrc = 0;
    logic [DW-1:0] mem = '0, alu = '0;
    logic [AW-1:0] rd = '0;

    int n_tests = 0;
    int n_fail  = 0;

    memwb_pipe_reg_if #(.DATA_W(DW), .ADDR_W(AW)) bus [ND] ();
    out_t got [ND];

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        assign bus[gi].stall_i    = stall;
        assign bus[gi].flush_i    = flush;
        assign bus[gi].valid_i    = valid;
        assign bus[gi].WB_i       = wb;
        assign bus[gi].WBSrc_i    = wbsrc;
        assign bus[gi].MemRdata_i = mem;
        assign bus[gi].ALUres_i   = alu;
        assign bus[gi].rd_addr_i  = rd;
        assign got[gi] = {bus[gi].valid_o, bus[gi].WB_o, bus[gi].WBSrc_o, bus[gi].MemRdata_o,
                          bus[gi].ALUres_o, bus[gi].rd_addr_o, bus[gi].wb_data_o, bus[gi].fwd_en_o};

        memwb_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(gi + 1)) dut (
            .clk_i (clk),
            .rst_i (rst_n),
            .bus   (bus[gi])
        );
    end

    // Reference model: mdl[d][k] is stage k of the DEPTH=d+1 pipe.
    st_t  mdl [ND][4];
    bit   armed = 0;
    out_t exp_q [ND][$];

    function automatic out_t view(st_t s);
        return {s.valid, s.wb, s.wbsrc, s.mem, s.alu, s.rd, (s.wbsrc ? s.mem : s.alu), s.wb};
    endfunction

    task automatic check(string name, out_t g, out_t e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, g, e);
        end
    endtask

    task automatic check_val(string name, logic [DW-1:0] g, logic [DW-1:0] e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, g, e);
        end
    endtask

    // Applies the rules for one rising edge using the inputs that were sampled.
    task automatic model_edge();
        st_t cap;
        cap.valid = valid;
        cap.wb    = wb && valid && (rd != 0);
        cap.wbsrc = wbsrc;
        cap.mem   = mem;
        cap.alu   = alu;
        cap.rd    = rd;
        if (!rst_n) begin
            for (int d = 0; d < ND; d++)
                for (int k = 0; k < 4; k++) mdl[d][k] = '0;
            armed = 0;
        end else if (!armed) begin
            armed = 1;
        end else begin
            for (int d = 0; d < ND; d++) begin
                for (int k = d; k >= 1; k--)
                    if (!stall) mdl[d][k] = mdl[d][k-1];
                if (flush)       mdl[d][0] = '0;
                else if (!stall) mdl[d][0] = cap;
            end
        end
        for (int d = 0; d < ND; d++) exp_q[d].push_back(view(mdl[d][d]));
    endtask

    // Starts and ends at a falling edge; one rising edge in between.
    task automatic step(bit s, bit f, bit v, bit w, bit src,
                        logic [DW-1:0] m, logic [DW-1:0] a, logic [AW-1:0] r);
        stall = s; flush = f; valid = v; wb = w; wbsrc = src; mem = m; alu = a; rd = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the immediate clear, holds it over
    // one edge and releases it at the following falling edge.
    task automatic async_reset(string tag);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) check($sformatf("%s_d%0d", tag, d + 1), got[d], '0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (exp_q[d].size() > 0) begin
                out_t e;
                e = exp_q[d].pop_front();
                check($sformatf("scoreboard_d%0d", d + 1), got[d], e);
            end
        end
    end

    initial begin
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < 4; k++) mdl[d][k] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) check($sformatf("reset_d%0d", d + 1), got[d], '0);
        @(negedge clk);
        rst_n = 1'b1;
        // Release edge: valid write presented but must not be captured.
        step(0, 0, 1, 1, 0, 32'h0, 32'hAAAA5555, 5'd4);
        check_val("release_no_capture", {31'b0, got[0].valid}, 32'd0);

        // 1: single capture
        step(0, 0, 1, 1, 0, 32'h0, 32'h1234, 5'd5);
        check_val("t1_wb_data", got[0].wbdata, 32'h00001234);
        check_val("t1_rd", {27'b0, got[0].rd}, 32'd5);
        check_val("t1_wb", {31'b0, got[0].wb}, 32'd1);

        // 2: load path, then write to register zero
        step(0, 0, 1, 1, 1, 32'hDEADBEEF, 32'h1, 5'd9);
        check_val("t2_load", got[0].wbdata, 32'hDEADBEEF);
        step(0, 0, 1, 1, 0, 32'h0, 32'h77, 5'd0);
        check_val("t2_r0_wb", {31'b0, got[0].wb}, 32'd0);
        check_val("t2_r0_fwd", {31'b0, got[0].fwd}, 32'd0);

        // 3: stall hold
        step(0, 0, 1, 1, 0, 32'h0, 32'h70, 5'd7);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 1, 0, 32'h0, 32'h30, 5'd3);
            check_val("t3_hold_rd", {27'b0, got[0].rd}, 32'd7);
        end
        step(0, 0, 1, 1, 0, 32'h0, 32'h30, 5'd3);
        check_val("t3_after_rd", {27'b0, got[0].rd}, 32'd3);

        // 4: flush with stall, DEPTH=2: B then A enter, B reaches stage 1
        step(0, 0, 1, 1, 0, 32'h0, 32'hB, 5'd11);
        step(0, 0, 1, 1, 0, 32'h0, 32'hA, 5'd12);
        step(1, 1, 1, 1, 0, 32'h0, 32'hC, 5'd13);
        check_val("t4_hold_B", {27'b0, got[1].rd}, 32'd11);
        check_val("t4_B_valid", {31'b0, got[1].valid}, 32'd1);
        step(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        check_val("t4_bubble_valid", {31'b0, got[1].valid}, 32'd0);
        check_val("t4_bubble_wb", {31'b0, got[1].wb}, 32'd0);

        // 5: DEPTH=3 latency
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1, 1, 0, 32'h0, 32'(i), (i <= 3) ? 5'(i) : 5'd0);
            if (i >= 3) check_val("t5_rd", {27'b0, got[2].rd}, 32'(i - 2));
        end

        // 6: asynchronous reset while valid data sits in the last stage
        repeat (3) step(0, 0, 1, 1, 0, 32'h0, 32'hFFFFFFFF, 5'd6);
        check_val("t6_pre_alu", got[0].alu, 32'hFFFFFFFF);
        async_reset("t6_async");
        step(0, 0, 1, 1, 1, 32'h12345678, 32'h0, 5'd8);
        check_val("t6_release_valid", {31'b0, got[0].valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit s, f, v, w, src;
            logic [AW-1:0] r;
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 6) == 0);
            v   = ($urandom_range(0, 4) != 0);
            w   = 1'($urandom_range(0, 1));
            src = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            if (i == 200) async_reset("rand_async");
            step(s, f, v, w, src, $urandom, $urandom, r);
        end

        step(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memwb_pipe_reg.md
Name: memwb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register for the 5-stage core, replacing the pass-through MEM/WB wiring with real clocked stage storage.
Captures write-back control, memory read data, ALU result and destination register at the clock edge. Supports stall, flush/bubble insertion, a per-stage valid bit and a configurable number of register stages.
Also provides the selected write-back value and a forwarding view of the last stage for the hazard/forwarding unit.

Parameters:
DATA_W, 32, width of memory read data and ALU result
ADDR_W, 5, width of destination register address
DEPTH, 1, number of register stages between MEM and WB; legal range 1..4

Ports:
clk_i  input  1  core clock, rising-edge active
rst_i  input  1  asynchronous, active-low reset
stall_i  input  1  hold all stages; no capture, no shift
flush_i  input  1  load a bubble into stage 0 on this edge
valid_i  input  1  MEM-stage instruction is valid
WB_i  input  1  register-write enable from MEM
WBSrc_i  input  1  write-back source select: 1 = memory data, 0 = ALU result
MemRdata_i  input  DATA_W  data read from data memory
ALUres_i  input  DATA_W  ALU result from MEM
rd_addr_i  input  ADDR_W  destination register
valid_o  output  1  last stage holds a valid instruction
WB_o  output  1  qualified register-write enable
WBSrc_o  output  1  registered source select
MemRdata_o  output  DATA_W  registered memory data
ALUres_o  output  DATA_W  registered ALU result
rd_addr_o  output  ADDR_W  registered destination register
wb_data_o  output  DATA_W  WBSrc_o ? MemRdata_o : ALUres_o (combinational from last stage)
fwd_en_o  output  1  WB_o; forwarding unit may match rd_addr_o

Behaviour:
- Reset (rst_i low, asynchronous): every stage's valid, WB, WBSrc, data and address fields clear to 0.
  - All outputs therefore read 0, including wb_data_o and fwd_en_o.
  - Reset asserted mid-stall or mid-flush also clears every stage.
  - Release is synchronous to the next rising edge; no capture occurs on the release edge.
- Latency: inputs appear at the outputs DEPTH rising edges after capture, counting only non-stalled edges.
- Stage chain: stage 0 loads from the inputs; stage k loads from stage k-1; the outputs come from stage DEPTH-1.
- stall_i=1: all stages hold their values, including valid.
  - Outputs stay stable for as long as stall_i is high.
- flush_i=1 with stall_i=0: stage 0 loads a bubble.
  - Bubble: valid=0, WB=0, WBSrc=0, data and address fields 0.
  - Older stages shift normally, so instructions already in flight are not killed.
- flush_i=1 with stall_i=1: flush wins for stage 0, which loads the bubble. Stages 1..DEPTH-1 hold.
  - With DEPTH=1 the single stage is bubbled.
- Write qualification, stored at capture: WB = WB_i & valid_i & (rd_addr_i != 0).
  - Register 0 is never written and never forwarded.
- Invalid input (valid_i=0): the data fields are still captured, but valid=0 and WB=0.
- wb_data_o is a pure 2:1 mux, with no extra register.
- Width rule: no arithmetic, no truncation; all fields are carried bit-exact.
- DEPTH outside 1..4: elaboration error through a generate-time check.

Decomposition:
- Shared package/header holds:
  - DATA_W and ADDR_W defaults
  - the constant REG_ZERO = 0
  - the bubble encoding
- One sub-module, memwb_stage:
  - a single clocked stage with d/q for valid, WB, WBSrc, MemRdata, ALUres and rd_addr, plus hold and bubble controls
  - the top instantiates DEPTH of them in a generate loop, then adds the qualification logic and the output mux.

Test Plan:
1. Reset then single capture, DEPTH=1: WB_i=1, valid_i=1, rd_addr_i=5, ALUres_i=0x1234, WBSrc_i=0 -> after 1 edge: WB_o=1, rd_addr_o=5, wb_data_o=0x00001234, valid_o=1.
2. Load path: WBSrc_i=1, MemRdata_i=0xDEADBEEF, rd_addr_i=9 -> wb_data_o=0xDEADBEEF. Then rd_addr_i=0, WB_i=1 -> WB_o=0, fwd_en_o=0.
3. Stall hold: capture rd_addr_i=7, then stall_i=1 for 3 edges while the inputs change to rd_addr_i=3 -> outputs stay at 7. After release, 3 appears 1 edge later.
4. Flush plus stall simultaneous, DEPTH=2, with valid instructions A and B in stages 0 and 1 -> stage 0 becomes a bubble and stage 1 still holds B. Next unstalled edge -> valid_o=0, WB_o=0.
5. DEPTH=3 latency: inject rd_addr_i=1,2,3 on consecutive edges with no stall -> rd_addr_o shows 1,2,3 starting on the 3rd edge after the first injection.
6. Asynchronous reset mid-operation: pull rst_i low between clock edges while valid_o=1 and ALUres_o=0xFFFFFFFF -> all outputs are 0 immediately, without waiting for an edge. After release, nothing is captured on the release edge.
